// File: rtl/aes_pkg.sv
// Shared AES helpers: inverse S-box, GF(2^8) multipliers and round-key selection
// from the 1408-bit expanded key schedule.
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int KW_AES128 = 128 * (NR_AES128 + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } inv_fsm_e;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [127:0] rk_slice(input logic [KW_AES128-1:0] w, input logic [3:0] r);
        return w[KW_AES128-1-128*int'(r) -: 128];
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational InvCipher round: InvShiftRows, InvSubBytes, AddRoundKey and,
// except on the final round, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] ark;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;

        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r was rotated left by r on encrypt, so byte (r,c) comes from column c-r.
            localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
            localparam int DST = 4 * c + r;
            assign ark[127-8*DST -: 8] = INV_SBOX[state_i[127-8*SRC -: 8]] ^ rk_i[127-8*DST -: 8];
        end

        assign a0 = ark[127-32*c -: 8];
        assign a1 = ark[119-32*c -: 8];
        assign a2 = ark[111-32*c -: 8];
        assign a3 = ark[103-32*c -: 8];

        assign state_o[127-32*c -: 32] = last_i ? ark[127-32*c -: 32] : {
            gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
            gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
            gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
            gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)
        };
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: one InvCipher round per clock between a
// valid/ready input handshake and a registered valid/ready output.
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int KW = 128 * (NR + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in,
    input  logic [KW-1:0] w,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out
);

    if (NR != NR_AES128 || KW != KW_AES128) begin : g_nr_check
        $error("aes_inv_cipher supports only NR=10 (AES-128)");
    end

    inv_fsm_e     fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         in_ready_q;
    logic         accept;
    logic [127:0] rk_cur;
    logic [127:0] round_out;

    assign accept = (fsm_q == ST_IDLE) && in_valid && in_ready_q;
    assign rk_cur = rk_slice(w, rnd_q);

    aes_inv_round u_round (
        .state_i (state_q),
        .rk_i    (rk_cur),
        .last_i  (rnd_q == 4'd0),
        .state_o (round_out)
    );

    // in_ready is registered so it stays low through reset and has no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= ST_IDLE;
            state_q    <= '0;
            rnd_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            in_ready_q <= (fsm_d == ST_IDLE);
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
                    fsm_d   = ST_BUSY;
                    state_d = in ^ rk_slice(w, 4'(NR_AES128));
                    rnd_d   = 4'(NR_AES128 - 1);
                end
            end
            ST_BUSY: begin
                state_d = round_out;
                if (rnd_q == 4'd0) fsm_d = ST_DONE;
                else               rnd_d = rnd_q - 4'd1;
            end
            ST_DONE: begin
                if (out_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (fsm_q == ST_DONE);
        out       = state_q;
    end

endmodule
